// File: rtl/piano_pkg.sv
// Shared note codes and scheduler state encoding for the piano datapath
// (keypad, song ROM, tone generator and scheduler all import this).
package piano_pkg;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_NONE = 4'd0;
  localparam note_t NOTE_C4   = 4'd1;
  localparam note_t NOTE_D4   = 4'd2;
  localparam note_t NOTE_E4   = 4'd3;
  localparam note_t NOTE_F4   = 4'd4;
  localparam note_t NOTE_G4   = 4'd5;
  localparam note_t NOTE_A4   = 4'd6;
  localparam note_t NOTE_B4   = 4'd7;
  localparam note_t NOTE_C5   = 4'd8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_MANUAL = 2'd3;

endpackage

// File: rtl/beat_divider.sv
// Quarter-beat divider: counts enabled cycles 0..TICKS_PER_QUARTER-1 and
// flags the terminal cycle. Holds its count while disabled (pause).
module beat_divider #(
  parameter int TICKS_PER_QUARTER = 25_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DW = $clog2(TICKS_PER_QUARTER);
  localparam logic [DW-1:0] TERM = DW'(TICKS_PER_QUARTER - 1);

  logic [DW-1:0] cnt;

  // Combinational so the top can register quarter_tick on the same edge as step.
  assign tick = enable && (cnt == TERM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/song_play_scheduler.sv
// Auto-play sequencer and keypad/song note arbiter. Steps the song ROM on
// each quarter beat and drives the single registered note code.
module song_play_scheduler
  import piano_pkg::*;
#(
  parameter int TICKS_PER_QUARTER = 25_000_000,
  parameter int SONG_LEN          = 64,
  localparam int SW               = $clog2(SONG_LEN)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MODE,
  input  logic          PLAY_BTN,
  input  logic          LOOP,
  input  logic [3:0]    key_note,
  input  logic [3:0]    song_note,
  output logic [SW-1:0] step,
  output logic          quarter_tick,
  output logic [3:0]    note_out,
  output logic          playing
);

  localparam logic [SW-1:0] LAST_STEP = SW'(SONG_LEN - 1);

  logic [1:0]    state, state_nxt;
  logic [SW-1:0] step_nxt;
  logic [3:0]    note_nxt;
  logic          div_clear, div_en, tick;

  assign div_en = (state == ST_PLAY) && !MODE;

  beat_divider #(.TICKS_PER_QUARTER(TICKS_PER_QUARTER)) u_div (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (div_clear),
    .enable (div_en),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    div_clear = 1'b0;
    if (MODE) begin
      state_nxt = ST_MANUAL;
      step_nxt  = '0;
      div_clear = 1'b1;
    end else begin
      case (state)
        ST_MANUAL: state_nxt = ST_IDLE;
        ST_IDLE: if (PLAY_BTN) begin
          state_nxt = ST_PLAY;
          step_nxt  = '0;
          div_clear = 1'b1;
        end
        ST_PLAY: begin
          if (PLAY_BTN) state_nxt = ST_PAUSE;
          // Step advance first; a LOOP=0 end then beats a same-cycle pause.
          if (tick) begin
            step_nxt = (step == LAST_STEP) ? '0 : step + 1'b1;
            if (step == LAST_STEP && !LOOP) begin
              state_nxt = ST_IDLE;
              div_clear = 1'b1;
            end
          end
        end
        ST_PAUSE: if (PLAY_BTN) state_nxt = ST_PLAY;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Note follows the state being entered so IDLE/PAUSE mute on the same edge.
  always_comb begin
    note_nxt = NOTE_NONE;
    case (state_nxt)
      ST_MANUAL: note_nxt = key_note;
      ST_PLAY:   note_nxt = (key_note != NOTE_NONE) ? key_note : song_note;
      default:   note_nxt = NOTE_NONE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      step         <= '0;
      quarter_tick <= 1'b0;
      note_out     <= NOTE_NONE;
      playing      <= 1'b0;
    end else begin
      state        <= state_nxt;
      step         <= step_nxt;
      quarter_tick <= tick;
      note_out     <= note_nxt;
      playing      <= (state_nxt == ST_PLAY);
    end
  end

endmodule

// File: tb/tb_song_play_scheduler.sv
// Bench for song_play_scheduler: directed scenarios plus random traffic,
// checked against a play-time based reference model.
module tb_song_play_scheduler;

  localparam int TPQ = 4;
  localparam int SL  = 8;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_MAN = 3;

  logic       CLK = 1'b0, RESET = 1'b0, MODE = 1'b0, PLAY_BTN = 1'b0, LOOP = 1'b1;
  logic [3:0] key_note = 4'd0;
  logic [3:0] song_note;
  logic [2:0] step;
  logic       quarter_tick, playing;
  logic [3:0] note_out;

  int checks = 0, errors = 0;

  // Model: play time in cycles; step and tick are derived from it arithmetically.
  int ms = M_IDLE, pc = 0, e_step = 0, e_tick = 0, e_note = 0, e_play = 0;

  song_play_scheduler #(.TICKS_PER_QUARTER(TPQ), .SONG_LEN(SL)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .PLAY_BTN(PLAY_BTN), .LOOP(LOOP),
    .key_note(key_note), .song_note(song_note), .step(step),
    .quarter_tick(quarter_tick), .note_out(note_out), .playing(playing)
  );

  assign song_note = 4'(step) + 4'd1;

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RESET) begin : model
    int ns, npc, oldstep;
    int tk;
    if (RESET) begin
      ms <= M_IDLE; pc <= 0; e_step <= 0; e_tick <= 0; e_note <= 0; e_play <= 0;
    end else begin
      ns = ms; npc = pc; tk = 0; oldstep = (pc / TPQ) % SL;
      if (MODE) begin
        ns = M_MAN; npc = 0;
      end else if (ms == M_MAN) begin
        ns = M_IDLE;
      end else if (ms == M_IDLE) begin
        if (PLAY_BTN) begin ns = M_PLAY; npc = 0; end
      end else if (ms == M_PAUSE) begin
        if (PLAY_BTN) ns = M_PLAY;
      end else begin
        npc = pc + 1;
        tk  = (npc % TPQ == 0) ? 1 : 0;
        if (PLAY_BTN) ns = M_PAUSE;
        if (tk == 1 && (npc / TPQ) % SL == 0 && !LOOP) begin ns = M_IDLE; npc = 0; end
      end
      ms     <= ns;
      pc     <= npc;
      e_tick <= tk;
      e_step <= (npc / TPQ) % SL;
      e_play <= (ns == M_PLAY) ? 1 : 0;
      e_note <= (ns == M_MAN) ? int'(key_note) :
                (ns == M_PLAY) ? ((key_note != 0) ? int'(key_note) : oldstep + 1) : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("step", 32'(step), e_step);
    chk("quarter_tick", 32'(quarter_tick), e_tick);
    chk("note_out", 32'(note_out), e_note);
    chk("playing", 32'(playing), e_play);
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic pulse_play();
    PLAY_BTN = 1'b1;
    cyc();
    PLAY_BTN = 1'b0;
  endtask

  // Bounded wait: number of cycles until quarter_tick is seen (limit on timeout).
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin cyc(); n++; end while (!quarter_tick && n < limit);
  endtask

  initial begin
    int n;
    logic [2:0] s0;

    // Reset
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_all();
    RESET = 1'b0;
    cyc();
    chk("reset_note", 32'(note_out), 0);
    chk("reset_playing", 32'(playing), 0);

    // Play from idle with loop
    LOOP = 1'b1;
    pulse_play();
    chk("play_start", 32'(playing), 1);
    chk("play_first_note", 32'(note_out), 1);
    wait_tick(10, n);
    chk("first_tick_latency", n, TPQ);
    chk("first_tick_step", 32'(step), 1);
    repeat (TPQ * SL) cyc();
    chk("loop_step", 32'(step), 1);

    // Pause two cycles after a tick, hold, then resume
    wait_tick(10, n);
    cyc();
    pulse_play();
    s0 = step;
    repeat (20) begin
      cyc();
      chk("pause_step_hold", 32'(step), 32'(s0));
      chk("pause_note", 32'(note_out), 0);
    end
    pulse_play();
    wait_tick(10, n);
    chk("resume_tick_latency", n, 2);

    // Keypad preemption at step 3
    n = 0;
    while (step != 3'd3 && n < 40) begin cyc(); n++; end
    chk("reach_step3", 32'(step), 3);
    key_note = 4'd5;
    cyc();
    chk("key_preempt", 32'(note_out), 5);
    s0 = step;
    repeat (6) cyc();
    chk("key_step_advances", 32'(step != s0), 1);
    key_note = 4'd0;
    cyc();
    cyc();
    chk("key_release", 32'(note_out), 32'(step) + 1);

    // Mode override with simultaneous PLAY_BTN
    MODE = 1'b1; PLAY_BTN = 1'b1; key_note = 4'd9;
    cyc();
    PLAY_BTN = 1'b0;
    chk("manual_step", 32'(step), 0);
    chk("manual_playing", 32'(playing), 0);
    chk("manual_note", 32'(note_out), 9);
    cyc();
    MODE = 1'b0; key_note = 4'd0;
    cyc();
    chk("manual_exit_note", 32'(note_out), 0);

    // Stop at end without loop
    LOOP = 1'b0;
    pulse_play();
    repeat (TPQ * SL) cyc();
    chk("end_tick", 32'(quarter_tick), 1);
    chk("end_step", 32'(step), 0);
    chk("end_playing", 32'(playing), 0);
    chk("end_note", 32'(note_out), 0);
    n = 0;
    repeat (2 * TPQ) begin cyc(); n += int'(quarter_tick); end
    chk("end_no_ticks", n, 0);

    // Async reset mid-play
    LOOP = 1'b1;
    pulse_play();
    repeat (TPQ + 2) cyc();
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_playing", 32'(playing), 0);
    chk("async_rst_step", 32'(step), 0);
    chk("async_rst_note", 32'(note_out), 0);
    chk("async_rst_tick", 32'(quarter_tick), 0);
    @(negedge CLK);
    check_all();
    RESET = 1'b0;
    repeat (3) cyc();
    chk("after_rst_idle", 32'(playing), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      MODE     = ($urandom_range(0, 24) == 0);
      PLAY_BTN = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) LOOP = ~LOOP;
      key_note = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
